// File: rtl/vit_pkg.sv
// -----------------------------------------------------------------------------
// vit_pkg
// Shared definitions for the Viterbi front-end: symbol/metric widths, the
// rate-1/2 codeword hypotheses, the branch-metric sequencer FSM state type and
// the 2-bit hard-decision Hamming distance helper.
// -----------------------------------------------------------------------------
package vit_pkg;

   localparam int SYM_W     = 2;  // bits per received symbol pair
   localparam int BM_W      = 2;  // metric width, distance range 0..2
   localparam int NUM_PAIRS = 8;  // symbols per packet

   // Codeword hypotheses compared against every received pair
   localparam logic [SYM_W-1:0] H00 = 2'b00;
   localparam logic [SYM_W-1:0] H01 = 2'b01;
   localparam logic [SYM_W-1:0] H10 = 2'b10;
   localparam logic [SYM_W-1:0] H11 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      WAIT_DEC,
      RENEW,
      HOLD
   } state_t;

   // Hamming distance between a received pair and a hypothesis
   function automatic logic [BM_W-1:0] hamming2(input logic [SYM_W-1:0] sym,
                                               input logic [SYM_W-1:0] hyp);
      logic [SYM_W-1:0] diff;
      diff = sym ^ hyp;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

endpackage

// File: rtl/bm_unit.sv
// -----------------------------------------------------------------------------
// bm_unit
// Combinational hard-decision branch-metric unit: one received 2-bit pair in,
// its Hamming distance to each of the four codeword hypotheses out.
//
// Ports
//   sym    in  2  received symbol pair
//   bm_00  out 2  distance to hypothesis 00
//   bm_01  out 2  distance to hypothesis 01
//   bm_10  out 2  distance to hypothesis 10
//   bm_11  out 2  distance to hypothesis 11
// -----------------------------------------------------------------------------
module bm_unit
   import vit_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic [BM_W-1:0]  bm_00,
   output logic [BM_W-1:0]  bm_01,
   output logic [BM_W-1:0]  bm_10,
   output logic [BM_W-1:0]  bm_11
);

   assign bm_00 = hamming2(sym, H00);
   assign bm_01 = hamming2(sym, H01);
   assign bm_10 = hamming2(sym, H10);
   assign bm_11 = hamming2(sym, H11);

endmodule

// File: rtl/branch_metric_sequencer.sv
// -----------------------------------------------------------------------------
// branch_metric_sequencer
// Captures one 8-pair packet from the Viterbi input buffer, streams the pairs
// one per bm_valid/bm_ready handshake (bit_pair_7 first) together with their
// four hard-decision branch metrics, then pulses renew so the buffer can load
// its next packet. With RENEW_WAIT = 1 the renew waits for decode_done.
//
// Ports
//   clk                      in  1  system clock, rising edge
//   rst                      in  1  synchronous active-low reset
//   buf_valid                in  1  buffer presents an unconsumed packet
//   bit_pair_7..bit_pair_0   in  2  received pairs, bit_pair_7 first in time
//   bm_ready                 in  1  downstream ACS accepts current symbol
//   decode_done              in  1  traceback finished for current packet
//   bm_valid                 out 1  metric/symbol outputs valid
//   bm_00, bm_01, bm_10, bm_11 out 2 distance of current pair to hypothesis
//   sym_idx                  out 3  position of current pair, 0 = bit_pair_7
//   sym_first                out 1  first pair of the packet on the outputs
//   sym_last                 out 1  last pair of the packet on the outputs
//   renew                    out 1  one-cycle pulse: buffer may reload
//   busy                     out 1  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module branch_metric_sequencer
   import vit_pkg::*;
#(
   parameter int NUM_PAIRS  = vit_pkg::NUM_PAIRS,
   parameter bit RENEW_WAIT = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             buf_valid,
   input  logic [SYM_W-1:0] bit_pair_7,
   input  logic [SYM_W-1:0] bit_pair_6,
   input  logic [SYM_W-1:0] bit_pair_5,
   input  logic [SYM_W-1:0] bit_pair_4,
   input  logic [SYM_W-1:0] bit_pair_3,
   input  logic [SYM_W-1:0] bit_pair_2,
   input  logic [SYM_W-1:0] bit_pair_1,
   input  logic [SYM_W-1:0] bit_pair_0,
   input  logic             bm_ready,
   input  logic             decode_done,
   output logic             bm_valid,
   output logic [BM_W-1:0]  bm_00,
   output logic [BM_W-1:0]  bm_01,
   output logic [BM_W-1:0]  bm_10,
   output logic [BM_W-1:0]  bm_11,
   output logic [2:0]       sym_idx,
   output logic             sym_first,
   output logic             sym_last,
   output logic             renew,
   output logic             busy
);

   localparam int         PKT_W    = SYM_W * NUM_PAIRS;
   localparam logic [2:0] LAST_IDX = 3'(NUM_PAIRS - 1);

   state_t             state;
   logic [PKT_W-1:0]   shadow;
   logic [2:0]         nxt_idx;
   logic [SYM_W-1:0]   load_sym;
   logic [BM_W-1:0]    m00, m01, m10, m11;

   assign nxt_idx = sym_idx + 3'd1;

   // Pair whose metrics get registered at the next edge: the incoming first
   // pair while idle, otherwise the shadow pair following the current one.
   always_comb begin
      // NOTE: assigning a default before the conditional keeps this block
      // purely combinational; a missing default would infer a latch.
      load_sym = bit_pair_7;
      if (state == STREAM) begin
         for (int i = 0; i < NUM_PAIRS; i++) begin
            if (nxt_idx == 3'(i)) load_sym = shadow[PKT_W-1-SYM_W*i -: SYM_W];
         end
      end
   end

   bm_unit u_bm_unit (
      .sym   (load_sym),
      .bm_00 (m00),
      .bm_01 (m01),
      .bm_10 (m10),
      .bm_11 (m11)
   );

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         // NOTE: the packet shadow is a data register but is still cleared on
         // reset so an abandoned packet can never be replayed afterwards.
         shadow    <= '0;
         sym_idx   <= '0;
         bm_valid  <= 1'b0;
         bm_00     <= '0;
         bm_01     <= '0;
         bm_10     <= '0;
         bm_11     <= '0;
         sym_first <= 1'b0;
         sym_last  <= 1'b0;
         renew     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         renew <= 1'b0;
         case (state)
            IDLE: begin
               if (buf_valid) begin
                  shadow    <= {bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4,
                                bit_pair_3, bit_pair_2, bit_pair_1, bit_pair_0};
                  sym_idx   <= '0;
                  bm_valid  <= 1'b1;
                  sym_first <= 1'b1;
                  sym_last  <= 1'b0;
                  bm_00     <= m00;
                  bm_01     <= m01;
                  bm_10     <= m10;
                  bm_11     <= m11;
                  busy      <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (bm_ready) begin
                  if (sym_idx == LAST_IDX) begin
                     bm_valid  <= 1'b0;
                     sym_idx   <= '0;
                     sym_first <= 1'b0;
                     sym_last  <= 1'b0;
                     bm_00     <= '0;
                     bm_01     <= '0;
                     bm_10     <= '0;
                     bm_11     <= '0;
                     if (RENEW_WAIT) begin
                        state <= WAIT_DEC;
                     end else begin
                        state <= RENEW;
                        renew <= 1'b1;
                     end
                  end else begin
                     sym_idx   <= nxt_idx;
                     sym_first <= 1'b0;
                     sym_last  <= (nxt_idx == LAST_IDX);
                     bm_00     <= m00;
                     bm_01     <= m01;
                     bm_10     <= m10;
                     bm_11     <= m11;
                  end
               end
            end
            WAIT_DEC: begin
               // Only a decode_done observed here counts; one coinciding with
               // the last handshake arrived while still in STREAM.
               if (decode_done) begin
                  state <= RENEW;
                  renew <= 1'b1;
               end
            end
            RENEW: begin
               state <= HOLD;
            end
            HOLD: begin
               // The buffer may still show the old packet this cycle, so
               // buf_valid is not looked at until IDLE.
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_metric_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_metric_sequencer
// Two sequencer instances: index 0 renews immediately (RENEW_WAIT = 0),
// index 1 waits for decode_done (RENEW_WAIT = 1). Expected outputs are derived
// from the packet contents with plain arithmetic at every negedge.
// -----------------------------------------------------------------------------
module tb_branch_metric_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        buf_valid   [2];
   logic        bm_ready    [2];
   logic        decode_done [2];
   logic [15:0] data        [2];
   logic        bm_valid    [2];
   logic [1:0]  bm_00       [2];
   logic [1:0]  bm_01       [2];
   logic [1:0]  bm_10       [2];
   logic [1:0]  bm_11       [2];
   logic [2:0]  sym_idx     [2];
   logic        sym_first   [2];
   logic        sym_last    [2];
   logic        renew       [2];
   logic        busy        [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_metric_sequencer #(.NUM_PAIRS(8), .RENEW_WAIT(1'b0)) u_nowait (
      .clk(clk), .rst(rst), .buf_valid(buf_valid[0]),
      .bit_pair_7(data[0][15:14]), .bit_pair_6(data[0][13:12]),
      .bit_pair_5(data[0][11:10]), .bit_pair_4(data[0][9:8]),
      .bit_pair_3(data[0][7:6]),   .bit_pair_2(data[0][5:4]),
      .bit_pair_1(data[0][3:2]),   .bit_pair_0(data[0][1:0]),
      .bm_ready(bm_ready[0]), .decode_done(decode_done[0]),
      .bm_valid(bm_valid[0]), .bm_00(bm_00[0]), .bm_01(bm_01[0]),
      .bm_10(bm_10[0]), .bm_11(bm_11[0]), .sym_idx(sym_idx[0]),
      .sym_first(sym_first[0]), .sym_last(sym_last[0]),
      .renew(renew[0]), .busy(busy[0])
   );

   branch_metric_sequencer #(.NUM_PAIRS(8), .RENEW_WAIT(1'b1)) u_wait (
      .clk(clk), .rst(rst), .buf_valid(buf_valid[1]),
      .bit_pair_7(data[1][15:14]), .bit_pair_6(data[1][13:12]),
      .bit_pair_5(data[1][11:10]), .bit_pair_4(data[1][9:8]),
      .bit_pair_3(data[1][7:6]),   .bit_pair_2(data[1][5:4]),
      .bit_pair_1(data[1][3:2]),   .bit_pair_0(data[1][1:0]),
      .bm_ready(bm_ready[1]), .decode_done(decode_done[1]),
      .bm_valid(bm_valid[1]), .bm_00(bm_00[1]), .bm_01(bm_01[1]),
      .bm_10(bm_10[1]), .bm_11(bm_11[1]), .sym_idx(sym_idx[1]),
      .sym_first(sym_first[1]), .sym_last(sym_last[1]),
      .renew(renew[1]), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic [31:0] observed,
                      input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Outputs outside streaming: no valid symbol, no renew, given busy level
   task automatic chk_quiet(input int u, input string tag, input logic exp_renew,
                            input logic exp_busy);
      chk({tag, "_bm_valid"}, 32'(bm_valid[u]), 32'd0);
      chk({tag, "_sym_last"}, 32'(sym_last[u]), 32'd0);
      chk({tag, "_renew"},    32'(renew[u]),    32'(exp_renew));
      chk({tag, "_busy"},     32'(busy[u]),     32'(exp_busy));
   endtask

   // Inputs that must be ignored outside IDLE: either the stale packet or noise
   task automatic drive_ignored(input int u, input logic [15:0] pkt, input bit stale);
      if (stale) begin
         buf_valid[u] = 1'b1;
         data[u]      = pkt;
      end else begin
         buf_valid[u] = 1'($urandom_range(0, 1));
         data[u]      = 16'($urandom);
      end
   endtask

   // One full packet on instance u, starting and ending at a negedge with the
   // instance idle. Returns with buf_valid low.
   task automatic run_packet(input int u, input logic [15:0] pkt, input bit rand_ready,
                             input int stall_idx, input int stall_len,
                             input int dec_delay, input bit stale);
      int         idx     = 0;
      int         hs      = 0;
      int         stalled = 0;
      int         cyc     = 0;
      logic [1:0] s;
      bit         rdy;
      data[u]        = pkt;
      buf_valid[u]   = 1'b1;
      bm_ready[u]    = 1'b0;
      decode_done[u] = 1'b0;
      @(negedge clk); cyc++;
      while (idx < 8 && cyc < 200) begin
         s = pkt[15 - 2*idx -: 2];
         chk("bm_valid",  32'(bm_valid[u]),  32'd1);
         chk("sym_idx",   32'(sym_idx[u]),   32'(idx));
         chk("sym_first", 32'(sym_first[u]), 32'(idx == 0));
         chk("sym_last",  32'(sym_last[u]),  32'(idx == 7));
         chk("bm_00", 32'(bm_00[u]), 32'($countones(s ^ 2'b00)));
         chk("bm_01", 32'(bm_01[u]), 32'($countones(s ^ 2'b01)));
         chk("bm_10", 32'(bm_10[u]), 32'($countones(s ^ 2'b10)));
         chk("bm_11", 32'(bm_11[u]), 32'($countones(s ^ 2'b11)));
         chk("busy_stream",  32'(busy[u]),  32'd1);
         chk("renew_stream", 32'(renew[u]), 32'd0);
         if (idx == stall_idx && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else if (rand_ready) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         bm_ready[u] = rdy;
         drive_ignored(u, pkt, stale);
         // decode_done coinciding with the last handshake must not count
         decode_done[u] = (idx == 7 && rdy) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk); cyc++;
         if (rdy) begin
            idx++;
            hs++;
         end
      end
      chk("handshakes", 32'(hs), 32'd8);
      bm_ready[u]    = 1'b0;
      decode_done[u] = 1'b0;
      if (u == 1) begin
         for (int i = 0; i < dec_delay; i++) begin
            chk_quiet(u, "wait_dec", 1'b0, 1'b1);
            drive_ignored(u, pkt, stale);
            @(negedge clk); cyc++;
         end
         decode_done[u] = 1'b1;
         @(negedge clk); cyc++;
         decode_done[u] = 1'b0;
      end
      chk_quiet(u, "renew_cyc", 1'b1, 1'b1);
      drive_ignored(u, pkt, stale);
      @(negedge clk); cyc++;
      chk_quiet(u, "hold_cyc", 1'b0, 1'b1);
      drive_ignored(u, pkt, stale);
      @(negedge clk); cyc++;
      chk_quiet(u, "idle_cyc", 1'b0, 1'b0);
      buf_valid[u] = 1'b0;
      if (u == 0 && !rand_ready && stall_len == 0) chk("period", 32'(cyc), 32'd11);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] pkt;
      // Reset with buf_valid high: nothing may be captured
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         buf_valid[u]   = 1'b1;
         bm_ready[u]    = 1'b1;
         decode_done[u] = 1'b0;
         data[u]        = 16'hA5A5;
      end
      @(negedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk_quiet(u, "reset", 1'b0, 1'b0);
         chk("reset_sym_idx",   32'(sym_idx[u]),   32'd0);
         chk("reset_sym_first", 32'(sym_first[u]), 32'd0);
         chk("reset_bm", {24'd0, bm_00[u], bm_01[u], bm_10[u], bm_11[u]}, 32'd0);
         buf_valid[u] = 1'b0;
         bm_ready[u]  = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk_quiet(0, "post_reset", 1'b0, 1'b0);

      // Directed packets
      run_packet(0, 16'hA5A5, 1'b0, -1, 0, 1, 1'b0);
      run_packet(0, 16'h5A5A, 1'b0, 2, 3, 1, 1'b0);
      run_packet(1, 16'h3C96, 1'b0, -1, 0, 5, 1'b0);

      // Stale buf_valid through RENEW/HOLD, then an all-ones packet
      run_packet(0, 16'h1E87, 1'b0, -1, 0, 1, 1'b1);
      run_packet(0, 16'hFFFF, 1'b0, -1, 0, 1, 1'b0);

      // Reset in the middle of a packet
      data[0]      = 16'hC3E1;
      buf_valid[0] = 1'b1;
      bm_ready[0]  = 1'b1;
      @(negedge clk);
      buf_valid[0] = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("pre_reset_sym_idx", 32'(sym_idx[0]), 32'd4);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_quiet(0, "mid_reset", 1'b0, 1'b0);
      chk("mid_reset_sym_idx", 32'(sym_idx[0]), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_quiet(0, "after_reset", 1'b0, 1'b0);
      end
      bm_ready[0] = 1'b0;
      run_packet(0, 16'h0F69, 1'b0, -1, 0, 1, 1'b0);

      // Randomized packets with random backpressure on both instances
      for (int k = 0; k < 12; k++) begin
         pkt = 16'($urandom);
         run_packet(k % 2, pkt, 1'b1, -1, 0, int'($urandom_range(1, 6)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
